// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch, exec and status signals between the sequencer and the core
interface fetch_sequencer_if;
   logic       run;
   logic       imemReq;
   logic [7:0] imemAddr;
   logic [7:0] imemData;
   logic       imemValid;
   logic [7:0] instrOut;
   logic       execStart;
   logic       execDone;
   logic       zeroFlag;
   logic [7:0] pcOut;
   logic       halted;
   logic       stackErr;
   modport master (
      input  run, imemData, imemValid, execDone, zeroFlag,
      output imemReq, imemAddr, instrOut, execStart, pcOut, halted, stackErr
   );
   modport slave (
      output run, imemData, imemValid, execDone, zeroFlag,
      input  imemReq, imemAddr, instrOut, execStart, pcOut, halted, stackErr
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/IR owner, fetch handshake, decode and exec sequencing; FETCH_SEQ_CALL_STACK_EN adds the CALL/RET stack
module fetch_sequencer #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter int         STACK_DEPTH = 4
) (
   input logic               clk,
   input logic               reset,
   fetch_sequencer_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
   localparam logic [2:0] OP_ALU  = 3'd1;
   localparam logic [2:0] OP_MEM  = 3'd2;
   localparam logic [2:0] OP_JMP  = 3'd3;
   localparam logic [2:0] OP_JZ   = 3'd4;
   localparam logic [2:0] OP_HLT  = 3'd7;
   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic       first_q;
   logic [2:0] opc;
   logic [7:0] inc;
   logic [7:0] tgt;
   if (STACK_DEPTH < 2 || STACK_DEPTH > 8) begin : g_depth_check
      $error("fetch_sequencer: STACK_DEPTH must be within 2..8");
   end
   assign opc = ir_q[7:5];
   assign inc = pc_q + 8'd1;
   // the jump page always comes from the instruction's own address, never from PC+1
   assign tgt = {pc_q[7:5], ir_q[4:0]};
`ifdef FETCH_SEQ_CALL_STACK_EN
   localparam logic [2:0] OP_CALL = 3'd5;
   localparam logic [2:0] OP_RET  = 3'd6;
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = $clog2(STACK_DEPTH);
   logic [SPW-1:0] sp_q, sp_d;
   logic [7:0]     stack_q [STACK_DEPTH];
   logic           err_q, err_d;
   logic           push;
   logic           full;
   logic           empty;
   logic [IW-1:0]  top_idx;
   assign full    = sp_q == SPW'(STACK_DEPTH);
   assign empty   = sp_q == '0;
   assign top_idx = IW'(sp_q - SPW'(1));
   // return-address storage; no reset needed because the pointer gates every read
   always_ff @(posedge clk) begin
      if (push) stack_q[IW'(sp_q)] <= inc;
   end
`endif
   // state, PC, IR and stack pointer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= 8'h00;
         first_q <= 1'b0;
`ifdef FETCH_SEQ_CALL_STACK_EN
         sp_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         first_q <= state_d == S_EXEC && state_q != S_EXEC;
`ifdef FETCH_SEQ_CALL_STACK_EN
         sp_q    <= sp_d;
         err_q   <= err_d;
`endif
      end
   end
   // next state plus PC/IR/stack updates; decode lasts exactly one cycle
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
`ifdef FETCH_SEQ_CALL_STACK_EN
      sp_d    = sp_q;
      err_d   = err_q;
      push    = 1'b0;
`endif
      case (state_q)
         S_IDLE: state_d = bus.run ? S_FETCH : S_IDLE;
         S_FETCH: begin
            ir_d    = bus.imemValid ? bus.imemData : ir_q;
            state_d = bus.imemValid ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            state_d = S_FETCH;
            pc_d    = inc;
            case (opc)
               OP_ALU, OP_MEM: state_d = S_EXEC;
               OP_JMP: pc_d = tgt;
               OP_JZ: pc_d = bus.zeroFlag ? tgt : inc;
`ifdef FETCH_SEQ_CALL_STACK_EN
               OP_CALL: begin
                  pc_d    = full ? pc_q : tgt;
                  state_d = full ? S_HALT : S_FETCH;
                  err_d   = err_q | full;
                  push    = !full;
                  sp_d    = full ? sp_q : sp_q + SPW'(1);
               end
               OP_RET: begin
                  pc_d    = empty ? pc_q : stack_q[top_idx];
                  state_d = empty ? S_HALT : S_FETCH;
                  err_d   = err_q | empty;
                  sp_d    = empty ? sp_q : sp_q - SPW'(1);
               end
`endif
               OP_HLT: begin
                  pc_d    = pc_q;
                  state_d = S_HALT;
               end
               default: ;
            endcase
         end
         S_EXEC: state_d = bus.execDone ? S_FETCH : S_EXEC;
         default: state_d = S_HALT;
      endcase
   end
   // Moore outputs from the current state and registers
   always_comb begin
      bus.imemReq   = state_q == S_FETCH;
      bus.imemAddr  = pc_q;
      bus.instrOut  = ir_q;
      bus.execStart = state_q == S_EXEC && first_q;
      bus.pcOut     = pc_q;
      bus.halted    = state_q == S_HALT;
`ifdef FETCH_SEQ_CALL_STACK_EN
      bus.stackErr  = err_q;
`else
      bus.stackErr  = 1'b0;
`endif
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: fetch_sequencer against an instruction-level model, directed and random programs
module tb_fetch_sequencer;
   localparam int DEPTH = 4;
   typedef struct {
      bit         rst, run, valid, done, zf, chk, req, start, hlt, err;
      logic [7:0] data, pc, ir;
   } cyc_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   fetch_sequencer_if bus();
   fetch_sequencer #(.RESET_PC(8'h00), .STACK_DEPTH(DEPTH)) dut (.clk(clk), .reset(rst), .bus(bus));
   cyc_t       q[$];
   logic [7:0] mem [256];
   logic [7:0] m_pc, m_ir;
   logic [7:0] stk[$];
   bit         m_err;
   bit         directed;
   bit         dzf;
   int         dexec;
   int         errors = 0;
   int         checks = 0;
   logic [7:0] fa[$];
   int         fc[$];
   int         n_start;

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [7:0] rd();
      return 8'($urandom);
   endfunction

   task automatic ck(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %02h expected %02h", nm, k, act, exp);
      end
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic add(input bit r, input bit run, input bit valid, input logic [7:0] data,
                      input bit done, input bit zf, input bit chk, input bit req,
                      input bit start, input bit hlt);
      cyc_t e;
      e.rst = r; e.run = run; e.valid = valid; e.data = data; e.done = done; e.zf = zf;
      e.chk = chk; e.req = req; e.start = start; e.hlt = hlt;
      e.pc = m_pc; e.ir = m_ir; e.err = m_err;
      q.push_back(e);
   endtask

   // one episode: reset, start, then interpret up to n_instr instructions
   task automatic gen(input int n_instr);
      int         w, d;
      logic [7:0] a, tgt;
      bit         zf, ex, hl;
      add(1, 0, 1, rd(), 1, 0, 0, 0, 0, 0);
      m_pc = 8'h00; m_ir = 8'h00; m_err = 0; stk.delete();
      repeat (directed ? 0 : $urandom_range(0, 2)) add(0, 0, 0, rd(), rb(), rb(), 1, 0, 0, 0);
      add(0, 1, 0, rd(), rb(), rb(), 1, 0, 0, 0);
      for (int n = 0; n < n_instr; n++) begin
         w = directed ? 0 : ($urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0);
         repeat (w) add(0, rb(), 0, rd(), rb(), rb(), 1, 1, 0, 0);
         add(0, rb(), 1, mem[m_pc], rb(), rb(), 1, 1, 0, 0);
         m_ir = mem[m_pc];
         a = m_pc;
         tgt = {a[7:5], m_ir[4:0]};
         zf = directed ? dzf : rb();
         add(0, rb(), 0, rd(), rb(), zf, 1, 0, 0, 0);
         ex = 0; hl = 0;
         m_pc = a + 8'd1;
         case (m_ir[7:5])
            3'd1, 3'd2: ex = 1;
            3'd3: m_pc = tgt;
            3'd4: if (zf) m_pc = tgt;
`ifdef FETCH_SEQ_CALL_STACK_EN
            3'd5: if (stk.size() == DEPTH) begin m_err = 1; hl = 1; m_pc = a; end
                  else begin stk.push_back(a + 8'd1); m_pc = tgt; end
            3'd6: if (stk.size() == 0) begin m_err = 1; hl = 1; m_pc = a; end
                  else m_pc = stk.pop_back();
`endif
            3'd7: begin hl = 1; m_pc = a; end
            default: ;
         endcase
         if (ex) begin
            d = directed ? dexec : $urandom_range(0, 4);
            for (int i = 0; i <= d; i++) add(0, rb(), 0, rd(), i == d, rb(), 1, 0, i == 0, 0);
         end
         if (hl) begin
            repeat (3) add(0, rb(), 0, rd(), rb(), rb(), 1, 0, 0, 1);
            return;
         end
      end
      repeat (directed ? 1 : $urandom_range(1, 3)) add(0, rb(), 0, rd(), rb(), rb(), 1, 1, 0, 0);
   endtask

   // drive each cycle's inputs after the edge, compare outputs on the falling edge
   task automatic play();
      cyc_t e;
      bit   prev = 0;
      int   k = 0;
      fa.delete(); fc.delete(); n_start = 0;
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk); #1;
         rst = e.rst; bus.run = e.run; bus.imemValid = e.valid; bus.imemData = e.data;
         bus.execDone = e.done; bus.zeroFlag = e.zf;
         @(negedge clk);
         if (e.chk) begin
            ck("imemReq", k, 8'(bus.imemReq), 8'(e.req));
            ck("imemAddr", k, bus.imemAddr, e.pc);
            ck("pcOut", k, bus.pcOut, e.pc);
            ck("instrOut", k, bus.instrOut, e.ir);
            ck("execStart", k, 8'(bus.execStart), 8'(e.start));
            ck("halted", k, 8'(bus.halted), 8'(e.hlt));
            ck("stackErr", k, 8'(bus.stackErr), 8'(e.err));
            if (bus.imemReq && !prev) begin
               fa.push_back(bus.imemAddr);
               fc.push_back(k - 1);
            end
            n_start += int'(bus.execStart);
         end
         prev = bus.imemReq;
         k++;
      end
   endtask

   initial begin
      bus.run = 0; bus.imemValid = 0; bus.imemData = 0; bus.execDone = 0; bus.zeroFlag = 0;
      directed = 1; dzf = 0; dexec = 0;
      fill(8'hE0); mem[8'h00] = 8'h00; mem[8'h01] = 8'h00;
      gen(5); play();
      ck("nop_fetch_count", 0, 8'(fa.size()), 8'd3);
      ck("nop_addr0", 1, fa[0], 8'h00); ck("nop_cyc0", 0, 8'(fc[0]), 8'd1);
      ck("nop_addr1", 3, fa[1], 8'h01); ck("nop_cyc1", 0, 8'(fc[1]), 8'd3);
      ck("nop_addr2", 5, fa[2], 8'h02); ck("nop_cyc2", 0, 8'(fc[2]), 8'd5);
      ck("nop_no_execStart", 0, 8'(n_start), 8'd0);
      ck("nop_halted", 0, 8'(bus.halted), 8'd1);
      fill(8'hE0);
      mem[8'h00] = 8'h7F; mem[8'h1F] = 8'h00; mem[8'h20] = 8'h7F; mem[8'h3F] = 8'h00;
      mem[8'h40] = 8'h67; mem[8'h47] = 8'h65;
      gen(10); play();
      ck("jmp_from_47", 0, fa[5], 8'h47); ck("jmp_to_45", 0, fa[6], 8'h45);
      fill(8'hE0); mem[8'h00] = 8'h7F; mem[8'h1F] = 8'h70;
      gen(10); play();
      ck("jmp_page0_kept", 0, fa[2], 8'h10);
      fill(8'hE0);
      for (int p = 0; p < 8; p++) begin
         mem[p * 32] = 8'h7F;
         mem[p * 32 + 31] = 8'h00;
      end
      gen(16); play();
      ck("wrap_from_ff", 0, fa[15], 8'hFF); ck("wrap_to_00", 0, fa[16], 8'h00);
      fill(8'hE0); mem[8'h00] = 8'h7F; mem[8'h1F] = 8'h70; mem[8'h10] = 8'h20;
      dexec = 3;
      gen(10); play();
      ck("alu_next_fetch", 0, fa[3], 8'h11); ck("alu_fetch_cycle", 0, 8'(fc[3]), 8'd11);
      ck("alu_one_start", 0, 8'(n_start), 8'd1);
      dexec = 0;
      fill(8'hE0); mem[8'h00] = 8'h7F; mem[8'h1F] = 8'h00; mem[8'h20] = 8'h88;
      dzf = 1; gen(10); play();
      ck("jz_taken", 0, fa[3], 8'h28);
      dzf = 0; gen(10); play();
      ck("jz_not_taken", 0, fa[3], 8'h21);
      fill(8'hE0); mem[8'h00] = 8'h7F; mem[8'h1F] = 8'h00; mem[8'h20] = 8'h70;
      mem[8'h30] = 8'hA2; mem[8'h22] = 8'hC0;
      gen(10); play();
`ifdef FETCH_SEQ_CALL_STACK_EN
      ck("call_target", 0, fa[4], 8'h22); ck("ret_target", 0, fa[5], 8'h31);
`else
      ck("call_as_nop", 0, fa[4], 8'h31);
`endif
      fill(8'hE0); mem[8'h00] = 8'hA0;
      gen(10); play();
`ifdef FETCH_SEQ_CALL_STACK_EN
      ck("overflow_stackErr", 0, 8'(bus.stackErr), 8'd1);
`else
      ck("no_stack_stackErr", 0, 8'(bus.stackErr), 8'd0);
`endif
      ck("overflow_halted", 0, 8'(bus.halted), 8'd1);
      gen(0); play();
      ck("reset_clears_halted", 0, 8'(bus.halted), 8'd0);
      ck("reset_clears_stackErr", 0, 8'(bus.stackErr), 8'd0);
      directed = 0;
      repeat (40) begin
         for (int i = 0; i < 256; i++) mem[i] = rd();
         gen($urandom_range(5, 30));
         play();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
